fetch_queue: RTL

Instruction prefetch queue between instruction memory and the decode stage of the five-stage MIPS pipeline. It owns the fetch PC, reads one instruction per cycle from the asynchronous-read instruction memory, and buffers up to DEPTH instruction/PC+4 pairs in a FIFO. Decode consumes them through a valid/ready handshake. A redirect from branch or jump resolution, misprediction recovery or an exception flushes the queue and restarts fetch at a new PC.

---
 rtl/fetch_queue.sv | 97 +++++++++
 1 files changed

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Instruction prefetch queue owning the fetch PC; buffers
//                {instr, pc+4} pairs for decode with flush-on-redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic [7:0]               imem_addr,
    input  logic [31:0]              imem_data,
    output logic                     out_valid,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_pcp4,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

    logic [31:0]        r_fetch_pc;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [31:0]        r_mem_instr [DEPTH];
    logic [31:0]        r_mem_pcp4  [DEPTH];

    logic               w_deq;
    logic               w_enq;
    logic               w_write;
    logic [31:0]        w_pc_plus4;
    logic               w_unused;

    // Low address bits of a redirect target are architecturally always zero.
    assign w_unused   = ^redirect_pc[1:0];

    assign w_pc_plus4 = r_fetch_pc + 32'd4;
    assign out_valid  = (r_count != '0);
    assign w_deq      = out_valid & out_ready;
    // A full queue can still take a word when the head leaves this cycle.
    assign w_enq      = (r_count < c_full) | w_deq;
    assign w_write    = w_enq & ~redirect;

    assign imem_addr  = r_fetch_pc[9:2];
    assign count      = r_count;

    always_comb begin
        out_instr = 32'h0;
        out_pcp4  = 32'h0;
        if (out_valid) begin
            out_instr = r_mem_instr[r_rd_ptr];
            out_pcp4  = r_mem_pcp4[r_rd_ptr];
        end
    end

    // Redirect squashes this cycle's fetch and any head being handed over.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else if (redirect) begin
            r_fetch_pc <= {redirect_pc[31:2], 2'b00};
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_enq) begin
                r_fetch_pc <= w_pc_plus4;
                r_wr_ptr   <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_deq) begin
                r_rd_ptr   <= r_rd_ptr + c_ptr_w'(1);
            end
            r_count <= r_count + c_cnt_w'(w_enq) - c_cnt_w'(w_deq);
        end
    end

    // Storage needs no reset: entries are only observed when count marks them valid.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem_instr[r_wr_ptr] <= imem_data;
            r_mem_pcp4[r_wr_ptr]  <= w_pc_plus4;
        end
    end

endmodule
`default_nettype wire
